// File: rtl/addh_pipe_pkg.sv
// Shared constants and geometry helpers for the pipelined adder/accumulator.
package addh_pipe_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_ACC = 1'b1;

  function automatic int nstg(input int width, input int seg);
    return width / seg;
  endfunction

  // The pipeline needs an exact slice split and at least one intermediate stage.
  function automatic logic geometry_ok(input int width, input int seg);
    return (seg > 32'sd0) && ((width % seg) == 32'sd0) && ((width / seg) >= 32'sd2);
  endfunction

endpackage

// File: rtl/addh_pipe_seg.sv
// Combinational SEG-bit ripple slice built from two half adders per bit.
module addh_pipe_seg
  import addh_pipe_pkg::*;
#(
  parameter int SEG = 4
) (
  input  logic [SEG-1:0] x,
  input  logic [SEG-1:0] y,
  input  logic           ci,
  output logic [SEG-1:0] s,
  output logic           co
);

  logic [SEG:0] c_s;

  // Ripple the carry through the slice, one half-adder pair per bit.
  always_comb begin
    c_s    = {(SEG + 1){1'b0}};
    s      = {SEG{1'b0}};
    c_s[0] = ci;
    for (int i = 0; i < SEG; i++) begin
      s[i]       = (x[i] ^ y[i]) ^ c_s[i];
      c_s[i + 1] = (x[i] & y[i]) | ((x[i] ^ y[i]) & c_s[i]);
    end
  end

  assign co = c_s[SEG];

endmodule

// File: rtl/addh_pipe_accum.sv
// Pipelined WIDTH-bit adder with carry-in, one SEG-bit slice per stage,
// valid/ready handshake, global stall and an accumulate mode with hazard lock.
module addh_pipe_accum
  import addh_pipe_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CI,
  input  logic             MODE,
  input  logic             CLR_ACC,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] S,
  output logic             CO,
  output logic [WIDTH-1:0] ACC
);

  localparam int NSTG = nstg(WIDTH, SEG);
  localparam int NMID = NSTG - 1;

  if (!geometry_ok(WIDTH, SEG)) begin : g_geom_check
    $error("addh_pipe_accum: WIDTH must be a multiple of SEG with at least two stages");
  end

  logic                       stall_s, accept_s, out_hs_s;
  logic                       acc_busy_r, out_mode_r;
  logic [WIDTH-1:0]           op_x_s, op_y_s;
  logic [NSTG-1:0][SEG-1:0]   sx_s, sy_s, ss_s;
  logic [NSTG-1:0]            sci_s, sco_s;
  logic [NSTG-1:0][WIDTH-1:0] nx_s;
  logic [NMID-1:0]            st_v_r, st_m_r, st_c_r;
  logic [NMID-1:0][WIDTH-1:0] st_x_r, st_y_r;
  logic                       unused_y_s;

  assign stall_s  = OUT_VALID && !OUT_READY;
  assign IN_READY = !RST && !stall_s && !acc_busy_r;
  assign accept_s = IN_VALID && IN_READY;
  assign out_hs_s = OUT_VALID && OUT_READY;

  // Resolved low bits of the last y copy are never needed again.
  assign unused_y_s = ^st_y_r[NMID-1][WIDTH-SEG-1:0];

  // Accumulate mode substitutes the accumulator for the first operand.
  always_comb begin
    op_x_s = A;
    op_y_s = B;
    case (MODE)
      MODE_ADD: begin
        op_x_s = A;
        op_y_s = B;
      end
      MODE_ACC: begin
        op_x_s = ACC;
        op_y_s = A;
      end
      default: begin
        op_x_s = A;
        op_y_s = B;
      end
    endcase
  end

  // nx_s[k]: the x word after slice k has replaced its bits with sum bits.
  for (genvar k = 0; k < NSTG; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign sx_s[k]  = op_x_s[SEG-1:0];
      assign sy_s[k]  = op_y_s[SEG-1:0];
      assign sci_s[k] = CI;
      assign nx_s[k]  = {op_x_s[WIDTH-1:SEG], ss_s[k]};
    end else begin : g_rest
      assign sx_s[k]  = st_x_r[k-1][k*SEG +: SEG];
      assign sy_s[k]  = st_y_r[k-1][k*SEG +: SEG];
      assign sci_s[k] = st_c_r[k-1];
      if (k == NSTG - 1) begin : g_last
        assign nx_s[k] = {ss_s[k], st_x_r[k-1][k*SEG-1:0]};
      end else begin : g_mid
        assign nx_s[k] = {st_x_r[k-1][WIDTH-1:(k+1)*SEG], ss_s[k], st_x_r[k-1][k*SEG-1:0]};
      end
    end

    addh_pipe_seg #(.SEG(SEG)) u_seg (
      .x  (sx_s[k]),
      .y  (sy_s[k]),
      .ci (sci_s[k]),
      .s  (ss_s[k]),
      .co (sco_s[k])
    );
  end

  // Pipeline advance; everything holds while the output is back-pressured.
  always_ff @(posedge CLK) begin
    if (RST) begin
      st_v_r     <= {NMID{1'b0}};
      st_m_r     <= {NMID{1'b0}};
      st_c_r     <= {NMID{1'b0}};
      st_x_r     <= {(NMID * WIDTH){1'b0}};
      st_y_r     <= {(NMID * WIDTH){1'b0}};
      OUT_VALID  <= 1'b0;
      out_mode_r <= 1'b0;
      S          <= {WIDTH{1'b0}};
      CO         <= 1'b0;
    end else if (!stall_s) begin
      st_v_r[0] <= accept_s;
      st_m_r[0] <= MODE;
      st_c_r[0] <= sco_s[0];
      st_x_r[0] <= nx_s[0];
      st_y_r[0] <= op_y_s;
      for (int k = 1; k < NMID; k++) begin
        st_v_r[k] <= st_v_r[k-1];
        st_m_r[k] <= st_m_r[k-1];
        st_c_r[k] <= sco_s[k];
        st_x_r[k] <= nx_s[k];
        st_y_r[k] <= st_y_r[k-1];
      end
      OUT_VALID  <= st_v_r[NMID-1];
      out_mode_r <= st_m_r[NMID-1];
      S          <= nx_s[NSTG-1];
      CO         <= sco_s[NSTG-1];
    end
  end

  // Accumulator write-back and the single-outstanding-accumulate lock.
  always_ff @(posedge CLK) begin
    if (RST) begin
      acc_busy_r <= 1'b0;
      ACC        <= {WIDTH{1'b0}};
    end else begin
      if (accept_s && (MODE == MODE_ACC)) begin
        acc_busy_r <= 1'b1;
      end else if (out_hs_s && (out_mode_r == MODE_ACC)) begin
        acc_busy_r <= 1'b0;
      end
      if (CLR_ACC) begin
        ACC <= {WIDTH{1'b0}};
      end else if (out_hs_s && (out_mode_r == MODE_ACC)) begin
        ACC <= S;
      end
    end
  end

endmodule

// File: tb/tb_addh_pipe_accum.sv
// Directed self-checking bench for addh_pipe_accum (WIDTH=16, SEG=4, four stages).
module tb_addh_pipe_accum;

  logic        CLK, RST, IN_VALID, CI, MODE, CLR_ACC, OUT_READY;
  logic [15:0] A, B;
  logic        IN_READY, OUT_VALID, CO;
  logic [15:0] S, ACC;

  int errors = 0;
  int checks = 0;

  localparam logic [15:0] T2_A  [4] = '{16'h1234, 16'h00FF, 16'h8000, 16'h0000};
  localparam logic [15:0] T2_B  [4] = '{16'h1111, 16'h0001, 16'h8000, 16'h0000};
  localparam logic        T2_CI [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
  localparam logic [15:0] T2_S  [4] = '{16'h2345, 16'h0100, 16'h0000, 16'h0001};
  localparam logic        T2_CO [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

  addh_pipe_accum #(.WIDTH(16), .SEG(4)) dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .A(A), .B(B), .CI(CI), .MODE(MODE), .CLR_ACC(CLR_ACC),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .S(S), .CO(CO), .ACC(ACC)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One accumulate op with bounded waits; reports what appeared at the output.
  task automatic acc_op(input logic [15:0] a, input logic ci, input logic clr_hs,
                        output logic [15:0] s_o, output logic co_o, output logic seen);
    seen = 1'b0; s_o = 16'h0000; co_o = 1'b0;
    IN_VALID = 1'b1; MODE = 1'b1; A = a; B = 16'hA5A5; CI = ci;
    #1;
    for (int i = 0; i < 8 && !IN_READY; i++) tick();
    tick();
    IN_VALID = 1'b0; MODE = 1'b0; CI = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (OUT_VALID) begin
        seen = 1'b1; s_o = S; co_o = CO;
        CLR_ACC = clr_hs;
        tick();
        CLR_ACC = 1'b0;
      end else begin
        tick();
      end
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    tick(); tick();
    checks++; if (IN_READY !== 1'b0) begin errors++; $display("FAIL rst_in_ready_high: got %b expected 0", IN_READY); end
    checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", OUT_VALID); end
    checks++; if (S !== 16'h0000) begin errors++; $display("FAIL rst_s: got %h expected 0000", S); end
    checks++; if (CO !== 1'b0) begin errors++; $display("FAIL rst_co: got %b expected 0", CO); end
    checks++; if (ACC !== 16'h0000) begin errors++; $display("FAIL rst_acc: got %h expected 0000", ACC); end
    RST = 1'b0;
    #1;
    checks++; if (IN_READY !== 1'b1) begin errors++; $display("FAIL rst_in_ready_low: got %b expected 1", IN_READY); end
    tick();
  endtask

  task automatic test_add_single();
    OUT_READY = 1'b1;
    IN_VALID = 1'b1; MODE = 1'b0; A = 16'hFFFF; B = 16'h0001; CI = 1'b0;
    #1;
    checks++; if (IN_READY !== 1'b1) begin errors++; $display("FAIL add1_ready: got %b expected 1", IN_READY); end
    tick();
    IN_VALID = 1'b0;
    tick(); tick();
    checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL add1_early_valid: got %b expected 0", OUT_VALID); end
    tick();
    checks++; if (OUT_VALID !== 1'b1) begin errors++; $display("FAIL add1_valid: got %b expected 1", OUT_VALID); end
    checks++; if (S !== 16'h0000) begin errors++; $display("FAIL add1_s: got %h expected 0000", S); end
    checks++; if (CO !== 1'b1) begin errors++; $display("FAIL add1_co: got %b expected 1", CO); end
    tick();
    checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL add1_single: got %b expected 0", OUT_VALID); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      IN_VALID = 1'b1; MODE = 1'b0; A = T2_A[i]; B = T2_B[i]; CI = T2_CI[i];
      #1;
      checks++; if (IN_READY !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d]: got %b expected 1", i, IN_READY); end
      tick();
    end
    IN_VALID = 1'b0; CI = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (OUT_VALID !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d]: got %b expected 1", i, OUT_VALID); end
      checks++; if (S !== T2_S[i]) begin errors++; $display("FAIL b2b_s[%0d]: got %h expected %h", i, S, T2_S[i]); end
      checks++; if (CO !== T2_CO[i]) begin errors++; $display("FAIL b2b_co[%0d]: got %b expected %b", i, CO, T2_CO[i]); end
      tick();
    end
    checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b expected 0", OUT_VALID); end
  endtask

  task automatic test_backpressure();
    IN_VALID = 1'b1; MODE = 1'b0; A = 16'h0101; B = 16'h0202; CI = 1'b0;
    tick();
    A = 16'h1000; B = 16'h0001;
    tick();
    IN_VALID = 1'b0;
    tick(); tick();
    OUT_READY = 1'b0;
    IN_VALID = 1'b1; A = 16'h0001; B = 16'h0001;
    #1;
    for (int j = 0; j < 3; j++) begin
      checks++; if (OUT_VALID !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b expected 1", j, OUT_VALID); end
      checks++; if (S !== 16'h0303) begin errors++; $display("FAIL bp_hold_s[%0d]: got %h expected 0303", j, S); end
      checks++; if (CO !== 1'b0) begin errors++; $display("FAIL bp_hold_co[%0d]: got %b expected 0", j, CO); end
      checks++; if (IN_READY !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", j, IN_READY); end
      tick();
    end
    OUT_READY = 1'b1; IN_VALID = 1'b0;
    #1;
    checks++; if (S !== 16'h0303) begin errors++; $display("FAIL bp_first_s: got %h expected 0303", S); end
    tick();
    checks++; if (OUT_VALID !== 1'b1) begin errors++; $display("FAIL bp_second_valid: got %b expected 1", OUT_VALID); end
    checks++; if (S !== 16'h1001) begin errors++; $display("FAIL bp_second_s: got %h expected 1001", S); end
    tick();
    checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL bp_no_dup: got %b expected 0", OUT_VALID); end
    tick();
  endtask

  task automatic test_accumulate();
    logic [15:0] exp_v;
    CLR_ACC = 1'b1;
    tick();
    CLR_ACC = 1'b0;
    checks++; if (ACC !== 16'h0000) begin errors++; $display("FAIL acc_clr: got %h expected 0000", ACC); end
    IN_VALID = 1'b1; MODE = 1'b1; A = 16'h0003; B = 16'h7777; CI = 1'b0;
    #1;
    for (int j = 0; j < 3; j++) begin
      exp_v = 16'h0003 * 16'(j + 1);
      checks++; if (IN_READY !== 1'b1) begin errors++; $display("FAIL acc_accept[%0d]: got %b expected 1", j, IN_READY); end
      tick();
      for (int c = 1; c <= 4; c++) begin
        checks++; if (IN_READY !== 1'b0) begin errors++; $display("FAIL acc_busy[%0d.%0d]: got %b expected 0", j, c, IN_READY); end
        if (c == 4) begin
          checks++; if (OUT_VALID !== 1'b1) begin errors++; $display("FAIL acc_valid[%0d]: got %b expected 1", j, OUT_VALID); end
          checks++; if (S !== exp_v) begin errors++; $display("FAIL acc_s[%0d]: got %h expected %h", j, S, exp_v); end
        end
        tick();
      end
      checks++; if (ACC !== exp_v) begin errors++; $display("FAIL acc_value[%0d]: got %h expected %h", j, ACC, exp_v); end
    end
    checks++; if (IN_READY !== 1'b1) begin errors++; $display("FAIL acc_ready_after: got %b expected 1", IN_READY); end
    IN_VALID = 1'b0; MODE = 1'b0;
    tick();
  endtask

  task automatic test_wrap_and_clear();
    logic [15:0] s_o;
    logic        co_o, seen;
    CLR_ACC = 1'b1; tick(); CLR_ACC = 1'b0;
    acc_op(16'hFFFE, 1'b0, 1'b0, s_o, co_o, seen);
    checks++; if (ACC !== 16'hFFFE) begin errors++; $display("FAIL wrap_load_acc: got %h expected fffe", ACC); end
    acc_op(16'h0003, 1'b0, 1'b0, s_o, co_o, seen);
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL wrap_timeout: got %b expected 1", seen); end
    checks++; if (s_o !== 16'h0001) begin errors++; $display("FAIL wrap_s: got %h expected 0001", s_o); end
    checks++; if (co_o !== 1'b1) begin errors++; $display("FAIL wrap_co: got %b expected 1", co_o); end
    checks++; if (ACC !== 16'h0001) begin errors++; $display("FAIL wrap_acc: got %h expected 0001", ACC); end
    CLR_ACC = 1'b1; tick(); CLR_ACC = 1'b0;
    acc_op(16'hFFFE, 1'b0, 1'b0, s_o, co_o, seen);
    acc_op(16'h0003, 1'b0, 1'b1, s_o, co_o, seen);
    checks++; if (s_o !== 16'h0001) begin errors++; $display("FAIL race_s: got %h expected 0001", s_o); end
    checks++; if (ACC !== 16'h0000) begin errors++; $display("FAIL race_clear_wins: got %h expected 0000", ACC); end
    acc_op(16'h0010, 1'b1, 1'b0, s_o, co_o, seen);
    checks++; if (s_o !== 16'h0011) begin errors++; $display("FAIL acc_ci_s: got %h expected 0011", s_o); end
    checks++; if (ACC !== 16'h0011) begin errors++; $display("FAIL acc_ci_acc: got %h expected 0011", ACC); end
  endtask

  task automatic test_reset_midflight();
    for (int i = 0; i < 3; i++) begin
      IN_VALID = 1'b1; MODE = 1'b0; A = 16'(i + 1); B = 16'h0001; CI = 1'b0;
      tick();
    end
    IN_VALID = 1'b0;
    RST = 1'b1;
    #1;
    checks++; if (IN_READY !== 1'b0) begin errors++; $display("FAIL mid_rst_ready: got %b expected 0", IN_READY); end
    tick();
    RST = 1'b0;
    #1;
    checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b expected 0", OUT_VALID); end
    checks++; if (ACC !== 16'h0000) begin errors++; $display("FAIL mid_rst_acc: got %h expected 0000", ACC); end
    checks++; if (IN_READY !== 1'b1) begin errors++; $display("FAIL mid_rst_ready_after: got %b expected 1", IN_READY); end
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL mid_rst_ghost[%0d]: got %b expected 0", c, OUT_VALID); end
    end
  endtask

  initial begin
    RST = 1'b1; IN_VALID = 1'b0; CI = 1'b0; MODE = 1'b0; CLR_ACC = 1'b0;
    OUT_READY = 1'b1; A = 16'h0000; B = 16'h0000;
    test_reset();
    test_add_single();
    test_back_to_back();
    test_backpressure();
    test_accumulate();
    test_wrap_and_clear();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/addh_pipe_accum.md
Name: addh_pipe_accum

Overview:
- Parametrised, pipelined successor to the half-adder cell: WIDTH-bit adder with carry-in, split into SEG-bit ripple slices, one slice per pipeline stage.
- Add mode computes A+B+CI. Accumulate mode computes ACC+A+CI into an internal accumulator.
- Valid/ready handshake on input and output, with global stall under backpressure.
- Sits in datapath macros that need a registered, throughput-1 adder.

Parameters:
- WIDTH, 16, operand/result width; must be a multiple of SEG.
- SEG, 4, bits resolved per pipeline stage. NSTG = WIDTH/SEG is the stage count and latency.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  synchronous, active-high reset.
- IN_VALID  input  1  operand presented.
- IN_READY  output  1  block accepts operand this cycle.
- A  input  WIDTH  operand A (addend in accumulate mode).
- B  input  WIDTH  operand B (ignored in accumulate mode).
- CI  input  1  carry-in.
- MODE  input  1  0 = add A+B+CI; 1 = accumulate ACC+A+CI.
- CLR_ACC  input  1  clear accumulator (independent of handshake).
- OUT_VALID  output  1  result valid.
- OUT_READY  input  1  consumer accepts result.
- S  output  WIDTH  sum.
- CO  output  1  carry out of the MSB.
- ACC  output  WIDTH  current accumulator value.

Behaviour:
- Reset:
  - Every stage valid bit, OUT_VALID, S, CO, ACC and acc_busy are 0.
  - IN_READY is 0 while RST is high.
  - RST mid-operation discards all in-flight operations; none emerge afterwards.
- Accept: an operation is accepted when IN_VALID && IN_READY. Operands A/B/CI/MODE are sampled into stage 0; in accumulate mode, ACC is sampled as the first operand.
- Pipeline:
  - Stage k adds bits [k*SEG +: SEG] plus the carry from stage k-1.
  - Stage k carries the lower result bits already resolved and the upper operand bits not yet used.
  - Last stage registers S/CO. OUT_VALID rises exactly NSTG cycles after the accept cycle.
- Stall:
  - stall = OUT_VALID && !OUT_READY. While stalled, all stage registers and S/CO/OUT_VALID hold.
  - Bubbles are not collapsed.
- IN_READY = !RST && !stall && !acc_busy (combinational from registered state and OUT_READY).
- Accumulate hazard:
  - acc_busy is set on accept of a MODE=1 op and cleared on that op's output handshake.
  - While acc_busy is set, no further ops are accepted, in either mode.
  - Accumulate throughput: one op per NSTG+1 cycles when OUT_READY=1.
- Accumulator update:
  - On output handshake of a MODE=1 op, ACC <= S at the same edge.
  - CO reflects the carry out of ACC+A+CI. ACC wraps modulo 2^WIDTH.
- CLR_ACC: sets ACC to 0 at the next edge. If it coincides with an accumulate write-back, the clear wins.
- Add mode: full throughput, one result per cycle. Results appear in accept order, with no reordering.
- Arithmetic: unsigned modulo 2^WIDTH. The slice carry chain is a half-adder ripple plus carry-in.

Decomposition:
- Package addh_pipe_pkg:
  - MODE_ADD/MODE_ACC constants.
  - nstg(WIDTH, SEG) function.
  - Elaboration check that WIDTH % SEG == 0.
- Sub-module addh_pipe_seg: combinational SEG-bit slice (inputs x, y, ci; outputs s, co), instantiated NSTG times.

Test Plan (WIDTH=16, SEG=4, NSTG=4):
1. Add, OUT_READY=1: A=0xFFFF, B=0x0001, CI=0 accepted at cycle 0 -> OUT_VALID=1 at cycle 4, S=0x0000, CO=1.
2. Streaming add: 4 back-to-back ops (0x1234+0x1111, 0x00FF+0x0001, 0x8000+0x8000, 0x0000+0x0000 with CI=1) -> IN_READY stays 1; results 0x2345/0, 0x0100/0, 0x0000/1, 0x0001/0 on consecutive cycles 4-7.
3. Backpressure: OUT_READY=0 for 3 cycles while OUT_VALID=1 -> S/CO held stable, IN_READY=0, no result lost or duplicated after OUT_READY returns to 1.
4. Accumulate: CLR_ACC pulse, then three MODE=1 ops with A=0x0003, CI=0 -> outputs 0x0003, 0x0006, 0x0009; consecutive accepts 5 cycles apart; final ACC=0x0009.
5. Accumulate wrap and clear race: ACC=0xFFFE, A=0x0003 -> S=0x0001, CO=1, ACC=0x0001. Repeat with CLR_ACC on the handshake cycle -> ACC=0x0000.
6. Reset mid-flight: 3 add ops in stages 0-2, RST high for 1 cycle -> OUT_VALID=0 and ACC=0 next cycle, no result in the following 6 cycles, IN_READY=1 after RST drops.
